// File: rtl/mem_pkg.sv
// Shared definitions for the data memory responder: widths, FSM states and
// the address legality check used when a request reaches the memory.
package mem_pkg;

  localparam int unsigned ADDR_W = 18;
  localparam int unsigned DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // A byte address is rejected when it is not word aligned or when its word
  // index falls beyond the implemented storage.
  function automatic logic addr_error(input logic [ADDR_W-1:0] addr,
                                      input int unsigned       depth_words);
    logic [31:0] word_idx;
    word_idx   = {16'd0, addr[ADDR_W-1:2]};
    addr_error = (addr[1:0] != 2'b00) || (word_idx >= depth_words);
  endfunction

endpackage

// File: rtl/data_mem_array.sv
// Word storage with a synchronous write port and a registered read port.
// Contents are deliberately not reset; only the read register is loaded on
// demand so it holds its value between accesses.
module data_mem_array
  import mem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter int unsigned IDX_W       = 12
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic              rd_en,
  input  logic [IDX_W-1:0]  idx,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH_WORDS];

  // Write the addressed word on a store, capture the addressed word on a load.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[idx] <= wdata;
    end
    if (rd_en) begin
      rdata <= mem[idx];
    end
  end

endmodule

// File: rtl/data_mem_responder.sv
// Single-outstanding load/store responder in front of a word memory.
// A request is accepted in IDLE, optionally waits WAIT_STATES cycles, touches
// the memory on the edge that enters RESP and then holds its response until
// the initiator consumes it.
module data_mem_responder
  import mem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err
);

  localparam int unsigned IDX_W    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0]  CNT_LOAD = 4'((WAIT_STATES > 0) ? (WAIT_STATES - 1) : 0);

  state_t            state;
  state_t            next_state;
  logic [3:0]        cnt;
  logic              accept;
  logic              enter_resp;

  logic              cap_write;
  logic [ADDR_W-1:0] cap_addr;
  logic [DATA_W-1:0] cap_wdata;

  logic              acc_write;
  logic [ADDR_W-1:0] acc_addr;
  logic [DATA_W-1:0] acc_wdata;
  logic              acc_err;

  logic              mem_we;
  logic              mem_re;
  logic [DATA_W-1:0] mem_rdata;

  logic              rd_ok;
  logic              err_q;

  // With zero wait states the memory is touched on the acceptance edge itself,
  // before the capture registers hold the request, so the live inputs are used
  // while in IDLE and the captured copy otherwise.
  assign acc_write = (state == IDLE) ? req_write : cap_write;
  assign acc_addr  = (state == IDLE) ? req_addr  : cap_addr;
  assign acc_wdata = (state == IDLE) ? req_wdata : cap_wdata;
  assign acc_err   = addr_error(acc_addr, DEPTH_WORDS);

  assign accept    = req_valid && req_ready;

  // Stores are suppressed while reset is held so a running clock cannot
  // corrupt memory during reset.
  assign mem_we    = enter_resp && acc_write && !acc_err && rst_n;
  assign mem_re    = enter_resp && !acc_write && !acc_err;

  assign resp_rdata = rd_ok ? mem_rdata : '0;
  assign resp_err   = err_q;

  // State register; reset returns to IDLE at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state decode and handshake outputs.
  always_comb begin
    next_state = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    enter_resp = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (WAIT_STATES == 0) begin
            next_state = RESP;
            enter_resp = 1'b1;
          end else begin
            next_state = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt == 4'd0) begin
          next_state = RESP;
          enter_resp = 1'b1;
        end
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) begin
          next_state = IDLE;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Wait-state down-counter, loaded on acceptance and run down in WAIT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= 4'd0;
    end else if (accept) begin
      cnt <= CNT_LOAD;
    end else if ((state == WAIT) && (cnt != 4'd0)) begin
      cnt <= cnt - 4'd1;
    end
  end

  // Capture the request on acceptance; reset discards a pending request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_write <= 1'b0;
      cap_addr  <= '0;
      cap_wdata <= '0;
    end else if (accept) begin
      cap_write <= req_write;
      cap_addr  <= req_addr;
      cap_wdata <= req_wdata;
    end
  end

  // Response qualifiers: set on RESP entry, held through RESP, cleared on exit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ok <= 1'b0;
      err_q <= 1'b0;
    end else if (enter_resp) begin
      rd_ok <= !acc_write && !acc_err;
      err_q <= acc_err;
    end else if ((state == RESP) && resp_ready) begin
      rd_ok <= 1'b0;
      err_q <= 1'b0;
    end
  end

  data_mem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .IDX_W       (IDX_W)
  ) u_array (
    .clk   (clk),
    .wr_en (mem_we),
    .rd_en (mem_re),
    .idx   (acc_addr[IDX_W+1:2]),
    .wdata (acc_wdata),
    .rdata (mem_rdata)
  );

endmodule
